// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the fetch-stage PC sequencer.
//   pc_state_t : sequencer state (BOOT, FETCH, REDIR_WAIT)
//   PC_INC     : sequential fetch stride in bytes
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        FETCH      = 2'd1,
        REDIR_WAIT = 2'd2
    } pc_state_t;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_target_sel.sv
// pc_target_sel: combinational redirect-target selection.
//   jalr_i        in   select JALR target (alu_result_i with bit 0 cleared)
//   pc_target_i   in   PC-relative branch/JAL target
//   alu_result_i  in   JALR target (rs1+imm)
//   target_o      out  redirect PC to load
//   misalign_o    out  target had bit 1 set and was replaced by TRAP_VECTOR
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned targets go to TRAP_VECTOR).
module pc_target_sel #(
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0004
) (
    input  logic                  jalr_i,
    input  logic [DATA_WIDTH-1:0] pc_target_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic [DATA_WIDTH-1:0] target_o,
    output logic                  misalign_o
);

    logic [DATA_WIDTH-1:0] raw_target;

    always_comb begin
        // JALR targets always have bit 0 forced low.
        raw_target = jalr_i ? (alu_result_i & ~DATA_WIDTH'(1)) : pc_target_i;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_o = raw_target[1];
        target_o   = raw_target[1] ? TRAP_VECTOR : raw_target;
`else
        misalign_o = 1'b0;
        target_o   = raw_target;
`endif
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, sequences PC+4 / branch / JALR redirects
// against hazard stalls and a valid/ready imem handshake, and raises the
// D/E flush pulses on a taken redirect.
//   clk_i, rst_i        clock, async active-high reset
//   StallF_i            hold fetch PC
//   PCSrcE_i, JalrE_i   redirect taken / redirect is JALR
//   PCTargetE_i         PC-relative target
//   ALUResultE_i        JALR target
//   IMemReady_i         imem accepts request this cycle
//   IMemReq_o, PCF_o    fetch request valid / request address
//   PCPlus4F_o          PCF_o + 4
//   InstrValidF_o       fetched instruction valid for D this cycle
//   FlushD_o, FlushE_o  combinational squash pulses
//   MisalignTrap_o      misaligned-redirect pulse (only with PC_MISALIGN_TRAP_EN)
// Optional feature macro: PC_MISALIGN_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0004
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  StallF_i,
    input  logic                  PCSrcE_i,
    input  logic                  JalrE_i,
    input  logic [DATA_WIDTH-1:0] PCTargetE_i,
    input  logic [DATA_WIDTH-1:0] ALUResultE_i,
    input  logic                  IMemReady_i,
    output logic                  IMemReq_o,
    output logic [DATA_WIDTH-1:0] PCF_o,
    output logic [DATA_WIDTH-1:0] PCPlus4F_o,
    output logic                  InstrValidF_o,
    output logic                  FlushD_o,
    output logic                  FlushE_o,
    output logic                  MisalignTrap_o
);

    pc_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] pcf_q, pcf_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    logic                  req_q, req_d;

    logic [DATA_WIDTH-1:0] target;
    logic                  misalign;
    logic                  accept;

    pc_target_sel #(
        .DATA_WIDTH  (DATA_WIDTH),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_target_sel (
        .jalr_i       (JalrE_i),
        .pc_target_i  (PCTargetE_i),
        .alu_result_i (ALUResultE_i),
        .target_o     (target),
        .misalign_o   (misalign)
    );

    assign accept     = req_q & IMemReady_i;
    assign IMemReq_o  = req_q;
    assign PCF_o      = pcf_q;
    assign PCPlus4F_o = pcf_q + DATA_WIDTH'(PC_INC);

    always_comb begin
        state_d        = state_q;
        pcf_d          = pcf_q;
        pend_d         = pend_q;
        InstrValidF_o  = 1'b0;
        FlushD_o       = 1'b0;
        FlushE_o       = 1'b0;
        MisalignTrap_o = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (PCSrcE_i) begin
                    FlushD_o       = 1'b1;
                    FlushE_o       = 1'b1;
                    MisalignTrap_o = misalign;
                    if (accept) begin
                        pcf_d = target;
                    end else begin
                        // Outstanding request must keep its address; park the target.
                        pend_d  = target;
                        state_d = REDIR_WAIT;
                    end
                end else if (accept) begin
                    InstrValidF_o = 1'b1;
                    if (!StallF_i) begin
                        pcf_d = pcf_q + DATA_WIDTH'(PC_INC);
                    end
                end
            end
            REDIR_WAIT: begin
                // A newer redirect supersedes the parked one, even on the accept cycle.
                if (PCSrcE_i) begin
                    FlushE_o       = 1'b1;
                    MisalignTrap_o = misalign;
                    pend_d         = target;
                end
                if (accept) begin
                    FlushD_o = 1'b1;
                    pcf_d    = PCSrcE_i ? target : pend_q;
                    state_d  = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        req_d = (state_d != BOOT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            pcf_q   <= RESET_PC;
            pend_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
        end
    end

endmodule
